pll_reset_sequencer: RTL and testbench

- Runs on the PLL reference clock. Drives the Gowin rPLL RESET input and supervises its LOCK output.
- Retries the PLL if lock does not arrive within a timeout.
- Once lock is stable, releases NUM_RST downstream synchronous resets in order, one every RELEASE_GAP cycles (e.g. SDRAM controller, then CPU, then peripherals).
- Successor to the fixed single-output PLL wrapper: adds supervision, retry and staged reset release.

---
 rtl/pll_reset_sequencer.sv | 196 +++++++++++++++++++
 tb/tb_pll_reset_sequencer.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/pll_reset_sequencer.sv
// rPLL reset/lock supervisor with timeout retry and staged downstream reset release.
// Optional LOCK_LOSS_RECOVERY_EN: lock loss reruns the sequence instead of latching FAULT.
module pll_reset_sequencer #(
    parameter int PLL_RST_CYCLES = 32,
    parameter int LOCK_TIMEOUT   = 27000,
    parameter int LOCK_STABLE    = 1024,
    parameter int NUM_RST        = 2,
    parameter int RELEASE_GAP    = 64,
    parameter int MAX_RETRY      = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               pll_lock,
    output logic               pll_reset,
    output logic [NUM_RST-1:0] rst_out,
    output logic               locked,
    output logic               fault,
    output logic [7:0]         retry_count,
    output logic [7:0]         lock_loss_count,
    output logic [2:0]         state
);

    localparam int M1   = (PLL_RST_CYCLES > LOCK_TIMEOUT) ? PLL_RST_CYCLES : LOCK_TIMEOUT;
    localparam int M2   = (LOCK_STABLE + 1 > RELEASE_GAP) ? LOCK_STABLE + 1 : RELEASE_GAP;
    localparam int MAXC = (M1 > M2) ? M1 : M2;
    localparam int CW   = $clog2(MAXC + 1);

    typedef enum logic [2:0] {
        S_PLL_RST   = 3'd0,
        S_WAIT_LOCK = 3'd1,
        S_STABLE    = 3'd2,
        S_RELEASE   = 3'd3,
        S_RUN       = 3'd4,
        S_FAULT     = 3'd5
    } state_e;

    state_e             state_q, state_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic               pll_reset_q, pll_reset_d;
    logic [NUM_RST-1:0] rst_out_q, rst_out_d;
    logic               locked_q, locked_d;
    logic               fault_q, fault_d;
    logic [7:0]         retry_q, retry_d;
    logic [7:0]         loss_q, loss_d;
    logic [1:0]         sync_q, sync_d;

    logic               lock_s;
    logic               lost;
    logic [7:0]         retry_inc;
    logic [NUM_RST-1:0] rel;

    assign lock_s = sync_q[1];

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        pll_reset_d = pll_reset_q;
        rst_out_d   = rst_out_q;
        locked_d    = locked_q;
        fault_d     = fault_q;
        retry_d     = retry_q;
        loss_d      = loss_q;
        sync_d      = {sync_q[0], pll_lock};
        lost        = 1'b0;
        retry_inc   = (retry_q == 8'hFF) ? retry_q : retry_q + 8'd1;
        // Shifting in zeros at the LSB releases bits strictly in index order
        rel         = rst_out_q << 1;

        unique case (state_q)
            S_PLL_RST: begin
                pll_reset_d = 1'b1;
                if (cnt_q == CW'(PLL_RST_CYCLES - 1)) begin
                    state_d     = S_WAIT_LOCK;
                    cnt_d       = '0;
                    pll_reset_d = 1'b0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_WAIT_LOCK: begin
                if (lock_s) begin
                    state_d = S_STABLE;
                    cnt_d   = '0;
                end else if (cnt_q == CW'(LOCK_TIMEOUT - 1)) begin
                    retry_d     = retry_inc;
                    cnt_d       = '0;
                    pll_reset_d = 1'b1;
                    if (retry_inc == 8'(MAX_RETRY)) begin
                        state_d = S_FAULT;
                        fault_d = 1'b1;
                    end else begin
                        state_d = S_PLL_RST;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_STABLE: begin
                if (!lock_s) begin
                    state_d = S_WAIT_LOCK;
                    cnt_d   = '0;
                end else if (cnt_q == CW'(LOCK_STABLE)) begin
                    cnt_d     = '0;
                    locked_d  = 1'b1;
                    rst_out_d = rel;
                    if (rel == '0) begin
                        state_d = S_RUN;
                        retry_d = 8'd0;
                    end else begin
                        state_d = S_RELEASE;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_RELEASE: begin
                if (!lock_s) begin
                    lost = 1'b1;
                end else if (cnt_q == CW'(RELEASE_GAP - 1)) begin
                    cnt_d     = '0;
                    rst_out_d = rel;
                    if (rel == '0) begin
                        state_d = S_RUN;
                        retry_d = 8'd0;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_RUN: begin
                lost = !lock_s;
            end
            S_FAULT: begin
                pll_reset_d = 1'b1;
                rst_out_d   = '1;
                locked_d    = 1'b0;
                fault_d     = 1'b1;
            end
            default: begin
                state_d     = S_PLL_RST;
                cnt_d       = '0;
                pll_reset_d = 1'b1;
                rst_out_d   = '1;
                locked_d    = 1'b0;
            end
        endcase

        if (lost) begin
            rst_out_d   = '1;
            locked_d    = 1'b0;
            loss_d      = (loss_q == 8'hFF) ? loss_q : loss_q + 8'd1;
            cnt_d       = '0;
            pll_reset_d = 1'b1;
`ifdef LOCK_LOSS_RECOVERY_EN
            state_d     = S_PLL_RST;
            retry_d     = 8'd0;
`else
            state_d     = S_FAULT;
            fault_d     = 1'b1;
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_PLL_RST;
            cnt_q       <= '0;
            pll_reset_q <= 1'b1;
            rst_out_q   <= '1;
            locked_q    <= 1'b0;
            fault_q     <= 1'b0;
            retry_q     <= 8'd0;
            loss_q      <= 8'd0;
            sync_q      <= 2'b00;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            pll_reset_q <= pll_reset_d;
            rst_out_q   <= rst_out_d;
            locked_q    <= locked_d;
            fault_q     <= fault_d;
            retry_q     <= retry_d;
            loss_q      <= loss_d;
            sync_q      <= sync_d;
        end
    end

    assign pll_reset       = pll_reset_q;
    assign rst_out         = rst_out_q;
    assign locked          = locked_q;
    assign fault           = fault_q;
    assign retry_count     = retry_q;
    assign lock_loss_count = loss_q;
    assign state           = state_q;

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// Directed bench for pll_reset_sequencer with small timing parameters.
// Edge numbering: E0 is the last edge with rst high; outputs sampled 1 ns after each edge.
module tb_pll_reset_sequencer;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       pll_lock = 1'b0;
    logic       pll_reset;
    logic [2:0] rst_out;
    logic       locked;
    logic       fault;
    logic [7:0] retry_count;
    logic [7:0] lock_loss_count;
    logic [2:0] state;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    pll_reset_sequencer #(
        .PLL_RST_CYCLES(4),
        .LOCK_TIMEOUT  (20),
        .LOCK_STABLE   (8),
        .NUM_RST       (3),
        .RELEASE_GAP   (5),
        .MAX_RETRY     (2)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .pll_lock       (pll_lock),
        .pll_reset      (pll_reset),
        .rst_out        (rst_out),
        .locked         (locked),
        .fault          (fault),
        .retry_count    (retry_count),
        .lock_loss_count(lock_loss_count),
        .state          (state)
    );

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_reset();
        rst      = 1'b1;
        pll_lock = 1'b0;
        tick(2);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst      = 1'b1;
        pll_lock = 1'b0;
        tick(2);
        checks++; if (state !== 3'd0) begin errors++; $display("FAIL reset_state got %0d exp 0", state); end
        checks++; if (pll_reset !== 1'b1) begin errors++; $display("FAIL reset_pll_reset got %b exp 1", pll_reset); end
        checks++; if (rst_out !== 3'b111) begin errors++; $display("FAIL reset_rst_out got %b exp 111", rst_out); end
        checks++; if (locked !== 1'b0) begin errors++; $display("FAIL reset_locked got %b exp 0", locked); end
        checks++; if (fault !== 1'b0) begin errors++; $display("FAIL reset_fault got %b exp 0", fault); end
        checks++; if (retry_count !== 8'd0) begin errors++; $display("FAIL reset_retry got %0d exp 0", retry_count); end
        checks++; if (lock_loss_count !== 8'd0) begin errors++; $display("FAIL reset_loss got %0d exp 0", lock_loss_count); end
        rst = 1'b0;
    endtask

    task automatic test_normal();
        int n;
        do_reset();
        tick(3);
        checks++; if (pll_reset !== 1'b1 || state !== 3'd0) begin errors++; $display("FAIL norm_prst_e3 got %b/%0d exp 1/0", pll_reset, state); end
        tick();
        checks++; if (pll_reset !== 1'b0 || state !== 3'd1) begin errors++; $display("FAIL norm_prst_e4 got %b/%0d exp 0/1", pll_reset, state); end
        tick(2);
        pll_lock = 1'b1;
        tick();
        n = 0;
        while (locked !== 1'b1 && n < 40) begin
            tick();
            n++;
        end
        checks++; if (n != 11) begin errors++; $display("FAIL norm_lock_latency got %0d exp 11", n); end
        checks++; if (rst_out !== 3'b110 || state !== 3'd3) begin errors++; $display("FAIL norm_rel0 got %b/%0d exp 110/3", rst_out, state); end
        tick(4);
        checks++; if (rst_out !== 3'b110) begin errors++; $display("FAIL norm_rel1_early got %b exp 110", rst_out); end
        tick();
        checks++; if (rst_out !== 3'b100 || state !== 3'd3) begin errors++; $display("FAIL norm_rel1 got %b/%0d exp 100/3", rst_out, state); end
        tick(4);
        checks++; if (rst_out !== 3'b100) begin errors++; $display("FAIL norm_rel2_early got %b exp 100", rst_out); end
        tick();
        checks++; if (rst_out !== 3'b000 || state !== 3'd4) begin errors++; $display("FAIL norm_run got %b/%0d exp 000/4", rst_out, state); end
        checks++; if (locked !== 1'b1 || retry_count !== 8'd0) begin errors++; $display("FAIL norm_run_flags got %b/%0d exp 1/0", locked, retry_count); end
    endtask

    task automatic test_timeout_fault();
        do_reset();
        tick(23);
        checks++; if (state !== 3'd1) begin errors++; $display("FAIL to_wait_e23 got %0d exp 1", state); end
        tick();
        checks++; if (state !== 3'd0 || retry_count !== 8'd1 || pll_reset !== 1'b1) begin errors++; $display("FAIL to_retry1 got %0d/%0d/%b exp 0/1/1", state, retry_count, pll_reset); end
        tick(3);
        checks++; if (pll_reset !== 1'b1) begin errors++; $display("FAIL to_pulse2 got %b exp 1", pll_reset); end
        tick();
        checks++; if (state !== 3'd1 || pll_reset !== 1'b0) begin errors++; $display("FAIL to_wait2 got %0d/%b exp 1/0", state, pll_reset); end
        tick(19);
        checks++; if (state !== 3'd1 || fault !== 1'b0) begin errors++; $display("FAIL to_wait2_end got %0d/%b exp 1/0", state, fault); end
        tick();
        checks++; if (state !== 3'd5 || fault !== 1'b1 || retry_count !== 8'd2) begin errors++; $display("FAIL to_fault got %0d/%b/%0d exp 5/1/2", state, fault, retry_count); end
        checks++; if (pll_reset !== 1'b1 || rst_out !== 3'b111) begin errors++; $display("FAIL to_fault_out got %b/%b exp 1/111", pll_reset, rst_out); end
        pll_lock = 1'b1;
        tick(10);
        checks++; if (state !== 3'd5 || fault !== 1'b1 || locked !== 1'b0) begin errors++; $display("FAIL to_fault_latch got %0d/%b/%b exp 5/1/0", state, fault, locked); end
    endtask

    task automatic test_glitch_then_loss();
        do_reset();
        pll_lock = 1'b1;
        tick(8);
        pll_lock = 1'b0;
        tick();
        pll_lock = 1'b1;
        tick();
        checks++; if (state !== 3'd2) begin errors++; $display("FAIL gl_stable got %0d exp 2", state); end
        tick();
        checks++; if (state !== 3'd1 || retry_count !== 8'd0) begin errors++; $display("FAIL gl_back_wait got %0d/%0d exp 1/0", state, retry_count); end
        tick();
        checks++; if (state !== 3'd2) begin errors++; $display("FAIL gl_restable got %0d exp 2", state); end
        tick(8);
        checks++; if (state !== 3'd2 || locked !== 1'b0) begin errors++; $display("FAIL gl_not_yet got %0d/%b exp 2/0", state, locked); end
        tick();
        checks++; if (locked !== 1'b1 || rst_out !== 3'b110 || state !== 3'd3) begin errors++; $display("FAIL gl_release got %b/%b/%0d exp 1/110/3", locked, rst_out, state); end
        // lock loss between first and second release
        pll_lock = 1'b0;
        tick(2);
        checks++; if (rst_out !== 3'b110 || state !== 3'd3) begin errors++; $display("FAIL loss_pre got %b/%0d exp 110/3", rst_out, state); end
        tick();
        checks++; if (rst_out !== 3'b111 || locked !== 1'b0 || lock_loss_count !== 8'd1) begin errors++; $display("FAIL loss_edge got %b/%b/%0d exp 111/0/1", rst_out, locked, lock_loss_count); end
`ifdef LOCK_LOSS_RECOVERY_EN
        checks++; if (state !== 3'd0 || pll_reset !== 1'b1 || retry_count !== 8'd0) begin errors++; $display("FAIL loss_rec got %0d/%b/%0d exp 0/1/0", state, pll_reset, retry_count); end
        pll_lock = 1'b1;
        tick(14);
        checks++; if (locked !== 1'b1 || state !== 3'd3 || rst_out !== 3'b110) begin errors++; $display("FAIL loss_rerun got %b/%0d/%b exp 1/3/110", locked, state, rst_out); end
`else
        checks++; if (state !== 3'd5 || fault !== 1'b1) begin errors++; $display("FAIL loss_fault got %0d/%b exp 5/1", state, fault); end
        pll_lock = 1'b1;
        tick(5);
        checks++; if (state !== 3'd5 || rst_out !== 3'b111 || pll_reset !== 1'b1) begin errors++; $display("FAIL loss_latch got %0d/%b/%b exp 5/111/1", state, rst_out, pll_reset); end
`endif
        checks++; if (lock_loss_count !== 8'd1) begin errors++; $display("FAIL loss_count_hold got %0d exp 1", lock_loss_count); end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++; if (lock_loss_count !== 8'd0 || state !== 3'd0 || fault !== 1'b0) begin errors++; $display("FAIL loss_clear got %0d/%0d/%b exp 0/0/0", lock_loss_count, state, fault); end
    endtask

    task automatic test_rst_in_run();
        do_reset();
        pll_lock = 1'b1;
        tick(23);
        checks++; if (state !== 3'd3 || rst_out !== 3'b100) begin errors++; $display("FAIL rr_pre got %0d/%b exp 3/100", state, rst_out); end
        tick();
        checks++; if (state !== 3'd4 || rst_out !== 3'b000) begin errors++; $display("FAIL rr_run got %0d/%b exp 4/000", state, rst_out); end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++; if (state !== 3'd0 || pll_reset !== 1'b1 || rst_out !== 3'b111) begin errors++; $display("FAIL rr_reset got %0d/%b/%b exp 0/1/111", state, pll_reset, rst_out); end
        checks++; if (locked !== 1'b0 || lock_loss_count !== 8'd0 || retry_count !== 8'd0) begin errors++; $display("FAIL rr_reset_cnt got %b/%0d/%0d exp 0/0/0", locked, lock_loss_count, retry_count); end
        tick(4);
        checks++; if (state !== 3'd1 || pll_reset !== 1'b0) begin errors++; $display("FAIL rr_wait got %0d/%b exp 1/0", state, pll_reset); end
        tick();
        checks++; if (state !== 3'd2) begin errors++; $display("FAIL rr_stable got %0d exp 2", state); end
    endtask

    task automatic test_lock_on_timeout();
        do_reset();
        tick(21);
        pll_lock = 1'b1;
        tick(2);
        checks++; if (state !== 3'd1) begin errors++; $display("FAIL lt_wait got %0d exp 1", state); end
        tick();
        checks++; if (state !== 3'd2 || retry_count !== 8'd0 || pll_reset !== 1'b0) begin errors++; $display("FAIL lt_stable got %0d/%0d/%b exp 2/0/0", state, retry_count, pll_reset); end
        tick(9);
        checks++; if (locked !== 1'b1 || state !== 3'd3) begin errors++; $display("FAIL lt_release got %b/%0d exp 1/3", locked, state); end
    endtask

    initial begin
        test_reset();
        test_normal();
        test_timeout_fault();
        test_glitch_then_loss();
        test_rst_in_run();
        test_lock_on_timeout();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
